// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - 640x480@60 raster timing constants shared by the display path
package display_pkg;

  localparam int CORDW = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam logic H_POL = 1'b0;
  localparam logic V_POL = 1'b0;

  localparam int H_TOTAL = H_BP + H_ACTIVE + H_FP + H_SYNC;
  localparam int V_TOTAL = V_BP + V_ACTIVE + V_FP + V_SYNC;

  // Region boundaries for the back porch, active, front porch, sync line order
  localparam int H_ACT_START  = H_BP;
  localparam int H_ACT_END    = H_BP + H_ACTIVE;
  localparam int H_SYNC_START = H_BP + H_ACTIVE + H_FP;
  localparam int V_ACT_START  = V_BP;
  localparam int V_ACT_END    = V_BP + V_ACTIVE;
  localparam int V_SYNC_START = V_BP + V_ACTIVE + V_FP;

  typedef logic [CORDW-1:0] coord_t;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - enable-gated counter that wraps from MAX to 0 and flags the wrap
module wrap_counter #(
  parameter int WIDTH = 10,
  parameter int MAX   = 799
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign wrap = inc && (count_q == WIDTH'(MAX));

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/display_timing.sv
// rtl/display_timing.sv - raster counters with registered de/sync/line/frame aligned to sx/sy
module display_timing
  import display_pkg::*;
#(
  parameter int   CORDW    = display_pkg::CORDW,
  parameter int   H_ACTIVE = display_pkg::H_ACTIVE,
  parameter int   H_FP     = display_pkg::H_FP,
  parameter int   H_SYNC   = display_pkg::H_SYNC,
  parameter int   H_BP     = display_pkg::H_BP,
  parameter int   V_ACTIVE = display_pkg::V_ACTIVE,
  parameter int   V_FP     = display_pkg::V_FP,
  parameter int   V_SYNC   = display_pkg::V_SYNC,
  parameter int   V_BP     = display_pkg::V_BP,
  parameter logic H_POL    = display_pkg::H_POL,
  parameter logic V_POL    = display_pkg::V_POL
) (
  input  logic             pix_clk,
  input  logic             rst_pix,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             line,
  output logic             frame
);

  localparam int H_TOT = H_BP + H_ACTIVE + H_FP + H_SYNC;
  localparam int V_TOT = V_BP + V_ACTIVE + V_FP + V_SYNC;

  localparam logic [CORDW-1:0] HA_START = CORDW'(H_BP);
  localparam logic [CORDW-1:0] HA_END   = CORDW'(H_BP + H_ACTIVE);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_BP + H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] VA_START = CORDW'(V_BP);
  localparam logic [CORDW-1:0] VA_END   = CORDW'(V_BP + V_ACTIVE);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_BP + V_ACTIVE + V_FP);

  logic [CORDW-1:0] sx_d;
  logic [CORDW-1:0] sy_d;
  logic             h_wrap;
  logic             v_wrap;

  wrap_counter #(.WIDTH(CORDW), .MAX(H_TOT - 1)) u_hcnt (
    .clk        (pix_clk),
    .rst        (rst_pix),
    .inc        (1'b1),
    .count      (sx),
    .count_next (sx_d),
    .wrap       (h_wrap)
  );

  wrap_counter #(.WIDTH(CORDW), .MAX(V_TOT - 1)) u_vcnt (
    .clk        (pix_clk),
    .rst        (rst_pix),
    .inc        (h_wrap),
    .count      (sy),
    .count_next (sy_d),
    .wrap       (v_wrap)
  );

  logic de_q, de_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic line_q, line_d;
  logic frame_q, frame_d;

  // Decode the next coordinates so each registered flag lands with the count it describes
  always_comb begin
    de_d    = (sx_d >= HA_START) && (sx_d < HA_END) && (sy_d >= VA_START) && (sy_d < VA_END);
    hsync_d = (sx_d >= HS_START) ? H_POL : ~H_POL;
    vsync_d = (sy_d >= VS_START) ? V_POL : ~V_POL;
    line_d  = h_wrap;
    frame_d = v_wrap;
  end

  always_ff @(posedge pix_clk or posedge rst_pix) begin
    if (rst_pix) begin
      de_q    <= 1'b0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign line  = line_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_display_timing.sv
// tb/tb_display_timing.sv - self-checking bench for display_timing against a raster position model
module tb_display_timing;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    bit hp; bit vp;
  } cfg_t;

  typedef struct {
    int sx; int sy;
    bit de; bit hs; bit vs; bit ln; bit fr;
  } exp_t;

  localparam cfg_t CA = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam cfg_t CB = '{8, 2, 3, 4, 6, 1, 2, 3, 1'b1, 1'b1};
  localparam cfg_t CC = '{640, 16, 96, 48, 4, 1, 2, 3, 1'b0, 1'b0};

  logic pix_clk = 1'b0;
  logic rst_pix = 1'b1;
  always #5 pix_clk = ~pix_clk;

  logic [9:0] sx_a, sy_a, sx_b, sy_b, sx_c, sy_c;
  logic de_a, hs_a, vs_a, ln_a, fr_a;
  logic de_b, hs_b, vs_b, ln_b, fr_b;
  logic de_c, hs_c, vs_c, ln_c, fr_c;

  display_timing u_dut_a (
    .pix_clk(pix_clk), .rst_pix(rst_pix), .sx(sx_a), .sy(sy_a), .de(de_a),
    .hsync(hs_a), .vsync(vs_a), .line(ln_a), .frame(fr_a)
  );

  display_timing #(
    .CORDW(10), .H_ACTIVE(CB.ha), .H_FP(CB.hf), .H_SYNC(CB.hs), .H_BP(CB.hb),
    .V_ACTIVE(CB.va), .V_FP(CB.vf), .V_SYNC(CB.vs), .V_BP(CB.vb),
    .H_POL(CB.hp), .V_POL(CB.vp)
  ) u_dut_b (
    .pix_clk(pix_clk), .rst_pix(rst_pix), .sx(sx_b), .sy(sy_b), .de(de_b),
    .hsync(hs_b), .vsync(vs_b), .line(ln_b), .frame(fr_b)
  );

  display_timing #(
    .CORDW(10), .H_ACTIVE(CC.ha), .H_FP(CC.hf), .H_SYNC(CC.hs), .H_BP(CC.hb),
    .V_ACTIVE(CC.va), .V_FP(CC.vf), .V_SYNC(CC.vs), .V_BP(CC.vb),
    .H_POL(CC.hp), .V_POL(CC.vp)
  ) u_dut_c (
    .pix_clk(pix_clk), .rst_pix(rst_pix), .sx(sx_c), .sy(sy_c), .de(de_c),
    .hsync(hs_c), .vsync(vs_c), .line(ln_c), .frame(fr_c)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;
  int k;
  int phase = 0;

  // Edges seen since the last reset release; position in the raster follows from it directly
  always @(posedge pix_clk or posedge rst_pix) begin
    if (rst_pix) k <= 0;
    else         k <= k + 1;
  end

  function automatic exp_t model(int kk, cfg_t c);
    exp_t e;
    int ht, vt, n, x, y;
    ht = c.hb + c.ha + c.hf + c.hs;
    vt = c.vb + c.va + c.vf + c.vs;
    n  = kk % (ht * vt);
    x  = n % ht;
    y  = n / ht;
    e.sx = x;
    e.sy = y;
    e.de = (x >= c.hb) && (x < c.hb + c.ha) && (y >= c.vb) && (y < c.vb + c.va);
    e.hs = (x >= c.hb + c.ha + c.hf) ? c.hp : !c.hp;
    e.vs = (y >= c.vb + c.va + c.vf) ? c.vp : !c.vp;
    e.ln = (x == 0);
    e.fr = (n == 0);
    return e;
  endfunction

  function automatic exp_t reset_exp(cfg_t c);
    exp_t e;
    e.sx = 0; e.sy = 0; e.de = 0; e.ln = 0; e.fr = 0;
    e.hs = !c.hp;
    e.vs = !c.vp;
    return e;
  endfunction

  function automatic logic [24:0] pack(exp_t e);
    logic [31:0] x, y;
    x = e.sx;
    y = e.sy;
    return {x[9:0], y[9:0], e.de, e.hs, e.vs, e.ln, e.fr};
  endfunction

  function automatic logic [24:0] mk(int sx, int sy, bit de, bit hs, bit vs, bit ln, bit fr);
    logic [31:0] x, y;
    x = sx;
    y = sy;
    return {x[9:0], y[9:0], de, hs, vs, ln, fr};
  endfunction

  task automatic cmp(string nm, logic [24:0] got, logic [24:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s got={sx,sy,de,hs,vs,ln,fr}=%h required=%h k=%0d t=%0t", nm, got, want, k, $time);
      end
    end
  endtask

  task automatic cmp_int(string nm, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d required=%0d", nm, got, want);
    end
  endtask

  function automatic logic [24:0] got_a();
    return {sx_a, sy_a, de_a, hs_a, vs_a, ln_a, fr_a};
  endfunction
  function automatic logic [24:0] got_b();
    return {sx_b, sy_b, de_b, hs_b, vs_b, ln_b, fr_b};
  endfunction
  function automatic logic [24:0] got_c();
    return {sx_c, sy_c, de_c, hs_c, vs_c, ln_c, fr_c};
  endfunction

  int b_de = 0, b_vs = 0, b_hs = 0, b_ln = 0, b_fr = 0;
  int c_de = 0, c_vs = 0, c_ln = 0, c_fr = 0;

  // Per-cycle check of every instance, sampled on the falling edge
  always @(negedge pix_clk) begin
    if (rst_pix || k == 0) begin
      cmp("cyc_a", got_a(), pack(reset_exp(CA)));
      cmp("cyc_b", got_b(), pack(reset_exp(CB)));
      cmp("cyc_c", got_c(), pack(reset_exp(CC)));
    end else begin
      cmp("cyc_a", got_a(), pack(model(k, CA)));
      cmp("cyc_b", got_b(), pack(model(k, CB)));
      cmp("cyc_c", got_c(), pack(model(k, CC)));
    end
    if (phase == 1 && !rst_pix && k >= 1) begin
      if (k <= 204) begin
        b_de += int'(de_b); b_vs += int'(vs_b); b_hs += int'(hs_b);
        b_ln += int'(ln_b); b_fr += int'(fr_b);
      end
      if (k <= 8000) begin
        c_de += int'(de_c); c_vs += int'(!vs_c); c_ln += int'(ln_c); c_fr += int'(fr_c);
      end
    end
  end

  task automatic wait_k(int target);
    int g;
    g = 0;
    while (k < target && g < 60000) begin
      @(posedge pix_clk);
      #1;
      g++;
    end
    cmp_int("wait_k", k, target);
  endtask

  initial begin
    int f_de, f_vs, f_ln, f_fr;
    exp_t e;

    // Model pinned against hand-derived default 640x480 positions
    cmp("pin_first",   pack(model(1, CA)),              mk(1, 0, 0, 1, 1, 0, 0));
    cmp("pin_de_rise", pack(model(33*800+48, CA)),      mk(48, 33, 1, 1, 1, 0, 0));
    cmp("pin_de_pre",  pack(model(33*800+47, CA)),      mk(47, 33, 0, 1, 1, 0, 0));
    cmp("pin_de_last", pack(model(512*800+687, CA)),    mk(687, 512, 1, 1, 1, 0, 0));
    cmp("pin_de_fall", pack(model(512*800+688, CA)),    mk(688, 512, 0, 1, 1, 0, 0));
    cmp("pin_hs_pre",  pack(model(5*800+703, CA)),      mk(703, 5, 0, 1, 1, 0, 0));
    cmp("pin_hs_on",   pack(model(5*800+704, CA)),      mk(704, 5, 0, 0, 1, 0, 0));
    cmp("pin_vs_pre",  pack(model(522*800+799, CA)),    mk(799, 522, 0, 0, 1, 0, 0));
    cmp("pin_vs_on",   pack(model(523*800, CA)),        mk(0, 523, 0, 1, 0, 1, 0));
    cmp("pin_line",    pack(model(800, CA)),            mk(0, 1, 0, 1, 1, 1, 0));
    cmp("pin_frame",   pack(model(420000, CA)),         mk(0, 0, 0, 1, 1, 1, 1));
    f_de = 0; f_vs = 0; f_ln = 0; f_fr = 0;
    for (int n = 1; n <= 420000; n++) begin
      e = model(n, CA);
      f_de += int'(e.de); f_vs += int'(!e.vs); f_ln += int'(e.ln); f_fr += int'(e.fr);
    end
    cmp_int("pin_frame_de",    f_de, 307200);
    cmp_int("pin_frame_vsync", f_vs, 1600);
    cmp_int("pin_frame_lines", f_ln, 525);
    cmp_int("pin_frame_count", f_fr, 1);

    repeat (2) @(negedge pix_clk);
    cmp("rst_a", got_a(), mk(0, 0, 0, 1, 1, 0, 0));
    cmp("rst_b", got_b(), mk(0, 0, 0, 0, 0, 0, 0));
    #1 rst_pix = 1'b0;
    phase = 1;

    wait_k(1);
    cmp("first_edge_a", got_a(), mk(1, 0, 0, 1, 1, 0, 0));
    wait_k(203);
    cmp("b_prewrap", got_b(), mk(16, 11, 0, 1, 1, 0, 0));
    wait_k(204);
    cmp("b_wrap", got_b(), mk(0, 0, 0, 0, 0, 1, 1));
    wait_k(205);
    cmp("b_after_wrap", got_b(), mk(1, 0, 0, 0, 0, 0, 0));
    wait_k(800);
    cmp("a_first_line", got_a(), mk(0, 1, 0, 1, 1, 1, 0));
    wait_k(801);
    cmp("a_line_once", got_a(), mk(1, 1, 0, 1, 1, 0, 0));
    wait_k(28000);
    phase = 2;

    cmp_int("b_frame_de",    b_de, 48);
    cmp_int("b_frame_vsync", b_vs, 34);
    cmp_int("b_frame_hsync", b_hs, 36);
    cmp_int("b_frame_lines", b_ln, 12);
    cmp_int("b_frame_count", b_fr, 1);
    cmp_int("c_frame_de",    c_de, 2560);
    cmp_int("c_frame_vsync", c_vs, 1600);
    cmp_int("c_frame_lines", c_ln, 10);
    cmp_int("c_frame_count", c_fr, 1);

    // Asynchronous resets at random raster positions
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(50, 4000)) @(posedge pix_clk);
      #2 rst_pix = 1'b1;
      #1;
      cmp("async_rst_a", got_a(), mk(0, 0, 0, 1, 1, 0, 0));
      cmp("async_rst_b", got_b(), mk(0, 0, 0, 0, 0, 0, 0));
      cmp("async_rst_c", got_c(), mk(0, 0, 0, 1, 1, 0, 0));
      repeat ($urandom_range(1, 3)) @(negedge pix_clk);
      #1 rst_pix = 1'b0;
      wait_k(1);
      cmp("rerelease_a", got_a(), mk(1, 0, 0, 1, 1, 0, 0));
      cmp("rerelease_b", got_b(), mk(1, 0, 0, 0, 0, 0, 0));
    end
    wait_k(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
